// File: rtl/lockin_pkg.sv
// rtl/lockin_pkg.sv - shared state type and width helpers for the lock-in demodulator
package lockin_pkg;

   typedef enum logic [1:0] {IDLE, MAC, WRAP} state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int acc_width(input int dw, input int log2n);
      return 2 * dw + log2n;
   endfunction

   function automatic int ch_width(input int nch);
      return (nch < 2) ? 1 : clog2(nch);
   endfunction

endpackage

// File: rtl/lockin_if.sv
// rtl/lockin_if.sv - sample-set input stream and per-channel I/Q result stream
interface lockin_if #(
   parameter int DW  = 16,
   parameter int NCH = 2
) ();
   import lockin_pkg::*;

   localparam int CHW = ch_width(NCH);

   logic                   s_valid;
   logic                   s_ready;
   logic [NCH*DW-1:0]      s_data;
   logic signed [DW-1:0]   ref_sin;
   logic signed [DW-1:0]   ref_cos;
   logic                   m_valid;
   logic                   m_ready;
   logic [CHW-1:0]         m_ch;
   logic signed [2*DW-1:0] m_i;
   logic signed [2*DW-1:0] m_q;

   modport master (
      output s_valid, s_data, ref_sin, ref_cos, m_ready,
      input  s_ready, m_valid, m_ch, m_i, m_q
   );

   modport slave (
      input  s_valid, s_data, ref_sin, ref_cos, m_ready,
      output s_ready, m_valid, m_ch, m_i, m_q
   );

endinterface

// File: rtl/lockin_mult.sv
// rtl/lockin_mult.sv - registered signed multiplier; single-stage form lets DW<=16 pack into one SB_MAC16
module lockin_mult #(
   parameter int DW = 16
) (
   input  logic                   clk,
   input  logic                   ce,
   input  logic signed [DW-1:0]   a,
   input  logic signed [DW-1:0]   b,
   output logic signed [2*DW-1:0] p
);

   always_ff @(posedge clk) begin
      if (ce) p <= (2*DW)'(a) * (2*DW)'(b);
   end

endmodule

// File: rtl/lockin_demod.sv
// rtl/lockin_demod.sv - multi-channel lock-in demodulator with one time-shared multiplier
module lockin_demod
   import lockin_pkg::*;
#(
   parameter int DW    = 16,
   parameter int NCH   = 2,
   parameter int LOG2N = 10
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    clear,
   lockin_if.slave bus,
   output logic    overrun
);

   localparam int ACCW = acc_width(DW, LOG2N);
   localparam int CHW  = ch_width(NCH);
   localparam int KW   = 5;
   localparam logic [KW-1:0]  K_LAST  = KW'(2*NCH - 1);
   localparam logic [CHW-1:0] CH_LAST = CHW'(NCH - 1);

   state_t                 state;
   logic [KW-1:0]          k;
   logic                   ready_q;
   logic                   accept;
   logic signed [DW-1:0]   x_q [NCH];
   logic signed [DW-1:0]   sin_q;
   logic signed [DW-1:0]   cos_q;
   logic signed [DW-1:0]   mul_a;
   logic signed [DW-1:0]   mul_b;
   logic                   mul_ce;
   logic signed [2*DW-1:0] prod;
   logic signed [ACCW-1:0] prod_ext;
   logic                   add_en;
   logic                   add_isq;
   logic [CHW-1:0]         add_ch;
   logic signed [ACCW-1:0] acc_i [NCH];
   logic signed [ACCW-1:0] acc_q [NCH];
   logic [LOG2N-1:0]       cnt;
   logic                   dump_pend;
   logic signed [2*DW-1:0] sh_i [NCH];
   logic signed [2*DW-1:0] sh_q [NCH];
   logic                   out_valid;
   logic [CHW-1:0]         out_ch;
   logic                   last_beat;
   logic                   sh_empty;

   assign bus.s_ready = ready_q && !clear;
   assign accept      = bus.s_valid && bus.s_ready;

   // Even k multiplies by sine (I), odd k by cosine (Q), channel k/2
   assign mul_a    = x_q[CHW'(k >> 1)];
   assign mul_b    = k[0] ? cos_q : sin_q;
   assign mul_ce   = (state == MAC);
   assign prod_ext = {{LOG2N{prod[2*DW-1]}}, prod};

   lockin_mult #(.DW(DW)) u_mult (
      .clk (clk),
      .ce  (mul_ce),
      .a   (mul_a),
      .b   (mul_b),
      .p   (prod)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         k         <= '0;
         ready_q   <= 1'b0;
         add_en    <= 1'b0;
         add_isq   <= 1'b0;
         add_ch    <= '0;
         cnt       <= '0;
         dump_pend <= 1'b0;
         sin_q     <= '0;
         cos_q     <= '0;
         for (int c = 0; c < NCH; c++) begin
            x_q[c]   <= '0;
            acc_i[c] <= '0;
            acc_q[c] <= '0;
         end
      end else if (clear) begin
         state     <= IDLE;
         k         <= '0;
         ready_q   <= 1'b1;
         add_en    <= 1'b0;
         cnt       <= '0;
         dump_pend <= 1'b0;
         for (int c = 0; c < NCH; c++) begin
            acc_i[c] <= '0;
            acc_q[c] <= '0;
         end
      end else begin
         add_en    <= (state == MAC);
         add_isq   <= k[0];
         add_ch    <= CHW'(k >> 1);
         dump_pend <= 1'b0;
         if (add_en) begin
            if (add_isq) acc_q[add_ch] <= acc_q[add_ch] + prod_ext;
            else         acc_i[add_ch] <= acc_i[add_ch] + prod_ext;
         end
         // Dump runs one cycle after WRAP, when no add can be in flight
         if (dump_pend) begin
            for (int c = 0; c < NCH; c++) begin
               acc_i[c] <= '0;
               acc_q[c] <= '0;
            end
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  for (int c = 0; c < NCH; c++) x_q[c] <= bus.s_data[c*DW +: DW];
                  sin_q   <= bus.ref_sin;
                  cos_q   <= bus.ref_cos;
                  k       <= '0;
                  ready_q <= 1'b0;
                  state   <= MAC;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            MAC: begin
               k <= k + KW'(1);
               if (k == K_LAST) state <= WRAP;
            end
            WRAP: begin
               cnt       <= cnt + LOG2N'(1);
               dump_pend <= (cnt == '1);
               ready_q   <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A final-beat handshake in the dump cycle frees the shadow for the new block
   assign last_beat = out_valid && bus.m_ready && (out_ch == CH_LAST);
   assign sh_empty  = !out_valid || last_beat;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_ch    <= '0;
         overrun   <= 1'b0;
         for (int c = 0; c < NCH; c++) begin
            sh_i[c] <= '0;
            sh_q[c] <= '0;
         end
      end else begin
         overrun <= 1'b0;
         if (out_valid && bus.m_ready) begin
            if (out_ch == CH_LAST) begin
               out_valid <= 1'b0;
               out_ch    <= '0;
            end else begin
               out_ch <= out_ch + CHW'(1);
            end
         end
         if (dump_pend) begin
            if (sh_empty) begin
               for (int c = 0; c < NCH; c++) begin
                  sh_i[c] <= acc_i[c][ACCW-1:LOG2N];
                  sh_q[c] <= acc_q[c][ACCW-1:LOG2N];
               end
               out_valid <= 1'b1;
               out_ch    <= '0;
            end else begin
               overrun <= 1'b1;
            end
         end
      end
   end

   assign bus.m_valid = out_valid;
   assign bus.m_ch    = out_ch;
   assign bus.m_i     = sh_i[out_ch];
   assign bus.m_q     = sh_q[out_ch];

endmodule

// File: tb/tb_lockin_demod.sv
// tb/tb_lockin_demod.sv - directed self-checking bench for lockin_demod (NCH=2, LOG2N=2, DW=16)
module tb_lockin_demod;

   logic clk = 1'b0;
   logic rst;
   logic clear;
   logic overrun;

   int n_checks = 0;
   int n_fail   = 0;
   int ovr_cnt  = 0;
   int ovr_base;

   lockin_if #(.DW(16), .NCH(2)) bus ();

   lockin_demod #(.DW(16), .NCH(2), .LOG2N(2)) dut (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .bus     (bus),
      .overrun (overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (overrun) ovr_cnt <= ovr_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int x0, input int x1, input int sn, input int cs);
      bus.s_data  = {16'(x1), 16'(x0)};
      bus.ref_sin = 16'(sn);
      bus.ref_cos = 16'(cs);
      bus.s_valid = 1'b1;
      for (int n = 0; n < 100 && !bus.s_ready; n++) tick();
      check("send_accept", longint'(bus.s_ready), 1);
      tick();
      bus.s_valid = 1'b0;
   endtask

   task automatic expect_beat(input string tag, input int ch, input longint i, input longint q);
      for (int n = 0; n < 60 && !bus.m_valid; n++) tick();
      check({tag, "_valid"}, longint'(bus.m_valid), 1);
      check({tag, "_ch"}, longint'(bus.m_ch), ch);
      check({tag, "_i"}, bus.m_i, i);
      check({tag, "_q"}, bus.m_q, q);
      bus.m_ready = 1'b1;
      tick();
      bus.m_ready = 1'b0;
   endtask

   task automatic expect_block(input string tag, input longint i0, input longint q0,
                               input longint i1, input longint q1);
      expect_beat({tag, "_b0"}, 0, i0, q0);
      expect_beat({tag, "_b1"}, 1, i1, q1);
      check({tag, "_drained"}, longint'(bus.m_valid), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_s_ready"}, longint'(bus.s_ready), 0);
      check({tag, "_m_valid"}, longint'(bus.m_valid), 0);
      check({tag, "_m_ch"}, longint'(bus.m_ch), 0);
      check({tag, "_m_i"}, bus.m_i, 0);
      check({tag, "_m_q"}, bus.m_q, 0);
      check({tag, "_overrun"}, longint'(overrun), 0);
   endtask

   initial begin
      int acc_t[4];
      int acc_n;
      int seen;
      logic stable;
      logic [0:0] snap_ch;
      logic signed [31:0] snap_i;
      logic signed [31:0] snap_q;

      rst         = 1'b1;
      clear       = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.ref_sin = '0;
      bus.ref_cos = '0;
      bus.m_ready = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      check("ready_after_rst_low", longint'(bus.s_ready), 0);
      tick();
      check("ready_after_rst_high", longint'(bus.s_ready), 1);

      // Basic I/Q
      ovr_base = ovr_cnt;
      repeat (4) send(1000, -1000, 16384, 0);
      expect_block("basic", 16384000, 0, -16384000, 0);
      check("basic_no_overrun", ovr_cnt - ovr_base, 0);

      // Most negative operands and mixed extremes
      repeat (4) send(-32768, -32768, -32768, -32768);
      expect_block("extreme_neg", 1073741824, 1073741824, 1073741824, 1073741824);
      repeat (4) send(-32768, -32768, 32767, -32768);
      expect_block("extreme_mix", -1073709056, 1073741824, -1073709056, 1073741824);

      // Throughput with s_valid held high
      bus.s_data  = {16'(3), 16'(2)};
      bus.ref_sin = 16'(4);
      bus.ref_cos = 16'(5);
      bus.s_valid = 1'b1;
      acc_n = 0;
      for (int n = 0; n < 100 && acc_n < 4; n++) begin
         if (bus.s_ready) begin
            acc_t[acc_n] = n;
            acc_n++;
         end
         tick();
      end
      bus.s_valid = 1'b0;
      check("thru_accepts", acc_n, 4);
      for (int j = 1; j < 4; j++) check("thru_gap", acc_t[j] - acc_t[j-1], 6);

      // Backpressure: stream held, input side keeps cycling
      for (int n = 0; n < 60 && !bus.m_valid; n++) tick();
      check("bp_valid", longint'(bus.m_valid), 1);
      snap_ch = bus.m_ch;
      snap_i  = bus.m_i;
      snap_q  = bus.m_q;
      bus.s_data  = '0;
      bus.s_valid = 1'b1;
      acc_n  = 0;
      stable = 1'b1;
      for (int n = 0; n < 10; n++) begin
         if (bus.s_ready) acc_n++;
         if (!bus.m_valid || bus.m_ch != snap_ch || bus.m_i != snap_i || bus.m_q != snap_q)
            stable = 1'b0;
         tick();
      end
      bus.s_valid = 1'b0;
      check("bp_accepts", acc_n, 2);
      check("bp_stable", longint'(stable), 1);
      clear = 1'b1;
      check("clear_ready_low", longint'(bus.s_ready), 0);
      tick();
      clear = 1'b0;
      expect_block("bp", 8, 10, 12, 15);

      // Overrun: two blocks with the stream stalled
      ovr_base = ovr_cnt;
      repeat (4) send(7, -7, 100, 200);
      repeat (4) send(9, 9, 1, 1);
      repeat (10) tick();
      check("overrun_pulses", ovr_cnt - ovr_base, 1);
      expect_block("overrun", 700, 1400, -700, -1400);

      // clear in the middle of a block
      repeat (2) send(500, 500, 100, -100);
      clear = 1'b1;
      check("clear_mid_ready_low", longint'(bus.s_ready), 0);
      tick();
      clear = 1'b0;
      repeat (4) send(10, 10, 100, -100);
      expect_block("clear_mid", 1000, -1000, 1000, -1000);

      // clear coinciding with s_valid drops that set
      bus.s_data  = {16'(1000), 16'(1000)};
      bus.ref_sin = 16'(1000);
      bus.ref_cos = 16'(1000);
      bus.s_valid = 1'b1;
      clear       = 1'b1;
      tick();
      clear       = 1'b0;
      bus.s_valid = 1'b0;
      repeat (4) send(3, 3, 2, 1);
      expect_block("clear_valid", 6, 3, 6, 3);

      // Reset during MAC
      send(1, 1, 1, 1);
      rst = 1'b1;
      tick();
      check_reset_outputs("rst_mac");
      rst = 1'b0;
      check("rst_mac_ready_low", longint'(bus.s_ready), 0);
      tick();
      check("rst_mac_ready_high", longint'(bus.s_ready), 1);

      // Reset during drain
      repeat (4) send(5, 5, 5, 5);
      expect_beat("rst_drain_b0", 0, 25, 25);
      check("rst_drain_pending", longint'(bus.m_valid), 1);
      rst = 1'b1;
      tick();
      check_reset_outputs("rst_drain");
      rst = 1'b0;
      bus.m_ready = 1'b1;
      seen = 0;
      for (int n = 0; n < 20; n++) begin
         if (bus.m_valid) seen++;
         tick();
      end
      bus.m_ready = 1'b0;
      check("rst_no_stale_beat", seen, 0);
      repeat (4) send(-4, 6, 50, -25);
      expect_block("post_rst", -200, 100, 300, -150);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
